// File: rtl/mdu_hilo_if.sv
// Operand/result bundle between the CPU control+datapath and the HI/LO multiply/divide unit.
// Latency: none, wires only.
// Backpressure: none here; the master holds off new starts while busy is high.
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             divz;
    logic             err;

    modport master (output start, func, a, b, input hi, lo, busy, done, divz, err);
    modport slave  (input start, func, a, b, output hi, lo, busy, done, divz, err);
endinterface

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with its own HI/LO pair: shift-add multiply, restoring divide, MTHI/MTLO moves.
// Latency: MTHI/MTLO write at the accepting edge; MULT/DIV busy WIDTH+1 cycles, done pulses with new HI/LO.
// Backpressure: start is only sampled while idle; it is silently dropped while busy.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    mdu_hilo_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               op_div;
    logic               sgn_q;
    logic               sgn_r;
    logic               dz;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;
    logic               divz_r;
    logic               err_r;

    logic               is_mul;
    logic               is_div;
    logic               is_sgn;
    logic               is_known;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    always_comb begin
        is_mul   = (bus.func == F_MULT) || (bus.func == F_MULTU);
        is_div   = (bus.func == F_DIV)  || (bus.func == F_DIVU);
        is_sgn   = (bus.func == F_MULT) || (bus.func == F_DIV);
        is_known = is_mul || is_div || (bus.func == F_MFHI) || (bus.func == F_MTHI)
                   || (bus.func == F_MFLO) || (bus.func == F_MTLO);
        a_neg    = is_sgn && bus.a[WIDTH-1];
        b_neg    = is_sgn && bus.b[WIDTH-1];
        a_mag    = a_neg ? -bus.a : bus.a;
        b_mag    = b_neg ? -bus.b : bus.b;
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] step_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
        if (op_div) begin
            step_nxt = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            step_nxt = {mul_sum, acc[WIDTH-1:1]};
        end
        prod_fix = sgn_q ? -acc : acc;
        q_fix    = sgn_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix    = sgn_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
            sgn_q  <= 1'b0;
            sgn_r  <= 1'b0;
            dz     <= 1'b0;
            opb    <= '0;
            acc    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
            divz_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (is_mul || is_div) begin
                            state  <= S_CALC;
                            cnt    <= '0;
                            op_div <= is_div;
                            divz_r <= 1'b0;
                            sgn_q  <= a_neg ^ b_neg;
                            sgn_r  <= a_neg;
                            dz     <= is_div && (bus.b == '0);
                            opb    <= is_div ? b_mag : a_mag;
                            acc    <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                        end else if (bus.func == F_MTHI) begin
                            hi_r <= bus.a;
                        end else if (bus.func == F_MTLO) begin
                            lo_r <= bus.a;
                        end else if (!is_known) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    acc <= step_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // a zero divisor leaves remainder = |a|, so the sign fix restores the dividend
                    if (op_div) begin
                        lo_r   <= dz ? '1 : q_fix;
                        hi_r   <= r_fix;
                        divz_r <= dz;
                    end else begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_r;
    assign bus.divz = divz_r;
    assign bus.err  = err_r;
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with its own HI/LO register pair.
- Sits directly downstream of the CPU datapath's A/B operand registers. When an R-type MULT/MULTU/DIV/DIVU/MTHI/MTLO executes, the control unit pulses start with the funct field.
- The datapath reads hi/lo back (MFHI/MFLO path into the register-file write mux).
- The control unit stalls on busy and resumes on done.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request strobe from control unit
- func  input  6  instruction funct field irout[5:0]
- a  input  WIDTH  operand rs (A register output)
- b  input  WIDTH  operand rt (B register output)
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  high while an iterative operation is in progress
- done  output  1  one-cycle pulse when HI/LO take an iterative result
- divz  output  1  sticky: last DIV/DIVU had b==0; cleared by next accepted iterative op
- err  output  1  one-cycle pulse: start with unsupported func

Behaviour:
- Reset (async, reset==0) forces:
  - hi=0, lo=0, busy=0, done=0, divz=0, err=0
  - state IDLE, iteration counter 0
  - any operation in flight is aborted with no write.
- Funct codes: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
- States:
  - IDLE: accepts start.
  - CALC: WIDTH cycles.
  - FIX: 1 cycle, sign correction and HI/LO write.
- start is sampled only in IDLE. While busy, start is ignored entirely: no err, no effect.
- MTHI/MTLO:
  - At the accepting edge, hi<=a (MTHI) or lo<=a (MTLO).
  - No busy, no done.
- MFHI/MFLO: accepted, no state change, no err. hi/lo are continuously driven.
- Any other func with start: err=1 for exactly the next cycle; nothing else changes.
- Iterative ops (MULT/MULTU/DIV/DIVU), start sampled at edge E0:
  - At E0, latch operands:
    - Signed ops: latch magnitudes.
    - Record result sign (MULT: a^b sign; DIV: quotient a^b, remainder sign of a).
    - Enter CALC with counter 0; busy=1 from E0.
  - CALC, each edge does one step:
    - Multiply: shift-add, 1 bit/edge, 2*WIDTH accumulator.
    - Divide: restoring, 1 quotient bit/edge.
    - Counter increments; after edge E0+WIDTH go to FIX.
  - FIX, edge E0+WIDTH+1:
    - Apply two's-complement negation per recorded sign.
    - Multiply: hi<=product[2W-1:W], lo<=product[W-1:0].
    - Divide: lo<=quotient, hi<=remainder.
    - busy<=0, done<=1 for one cycle.
  - Total: busy high for WIDTH+1 cycles; new HI/LO visible in the cycle done is high.
- Divide by zero (b==0, DIV or DIVU):
  - Runs full latency.
  - Result lo=all ones, hi=a (unmodified dividend).
  - divz=1 from the FIX edge until the next accepted iterative op's E0.
- Signed overflow, DIV with a=0x80000000 and b=0xFFFFFFFF: lo=0x80000000, hi=0. No flag.
- hi/lo are unchanged throughout CALC. An operation that is aborted by reset never writes.
- start in the same cycle done is high: accepted (state is already IDLE). Back-to-back ops are therefore spaced WIDTH+2 cycles apart.
- Operands a/b may change after E0 without effect.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=5 -> busy for 33 cycles, done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT of the same operands -> hi=0, lo=1.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2, divz=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, divz=1. Next MULT clears divz at its accept edge.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake and reset cases:
  - MTHI a=0xA5A5A5A5 -> hi updated next cycle, no busy/done.
  - start with func=0x20 -> err pulse, hi/lo unchanged.
  - start MULT during busy -> ignored.
  - Assert reset at CALC cycle 10 -> busy=0, hi=lo=0, no done.
